// File: rtl/divide_unit_pkg.sv
// Shared definitions for the multi-cycle integer divider.
// Holds the FSM state type, the fixed result latency and the UDIV/SDIV opcode fields.
// Imported by the divider top and its restoring-step datapath.
package divide_unit_pkg;

   localparam int WORD        = 64;
   localparam int DIV_LATENCY = WORD + 2;

   // Data-processing (2 source) encoding: shared opcode field, op selected by shamt
   localparam logic [10:0] DIV_OPCODE = 11'b10011010110;
   localparam logic [5:0]  UDIV_SHAMT = 6'b000010;
   localparam logic [5:0]  SDIV_SHAMT = 6'b000011;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, subtract divisor if it fits.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
module div_step #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic [WIDTH-1:0] i_quo,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH-1:0] o_rem,
   output logic [WIDTH-1:0] o_quo
);

   logic [WIDTH:0] w_trial;

   // Trial remainder keeps the shifted-out MSB so the compare never overflows
   always_comb begin
      w_trial = {i_rem, i_quo[WIDTH-1]};
      o_rem   = w_trial[WIDTH-1:0];
      o_quo   = {i_quo[WIDTH-2:0], 1'b0};
      if (w_trial >= {1'b0, i_divisor}) begin
         o_rem    = w_trial[WIDTH-1:0] - i_divisor;
         o_quo[0] = 1'b1;
      end
   end

endmodule

// File: rtl/divide_unit.sv
// Multi-cycle UDIV/SDIV divider (restoring, one quotient bit per cycle).
// Latency: fixed, done pulses WIDTH+2 cycles after the cycle start is presented.
// Backpressure: start is only accepted in IDLE; busy holds the fetch stage meanwhile.
module divide_unit
   import divide_unit_pkg::*;
#(
   parameter int WIDTH = WORD
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic             i_signed_op,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder,
   output logic             o_div_by_zero
);

   localparam int CNT_W = $clog2(WIDTH);

   div_state_t       r_state;
   div_state_t       w_state_nxt;
   logic             w_busy;
   logic             w_done;

   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_dvs;
   logic [CNT_W-1:0] r_cnt;
   logic             r_sign_q;
   logic             r_sign_r;
   logic             r_divz;

   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_div_by_zero;

   logic [WIDTH-1:0] w_abs_a;
   logic [WIDTH-1:0] w_abs_b;
   logic [WIDTH-1:0] w_rem_nxt;
   logic [WIDTH-1:0] w_quo_nxt;

   // Magnitudes only in signed mode; in unsigned mode the MSB is plain magnitude
   assign w_abs_a = (i_signed_op && i_dividend[WIDTH-1]) ? -i_dividend : i_dividend;
   assign w_abs_b = (i_signed_op && i_divisor[WIDTH-1])  ? -i_divisor  : i_divisor;

   div_step #(.WIDTH(WIDTH)) u_step (
      .i_rem     (r_rem),
      .i_quo     (r_quo),
      .i_divisor (r_dvs),
      .o_rem     (w_rem_nxt),
      .o_quo     (w_quo_nxt)
   );

   // State register; reset drops any operation in flight without a done pulse
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and status outputs; start outside IDLE (including DONE) is ignored
   always_comb begin
      w_state_nxt = r_state;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_state_nxt = CALC;
            end
         end
         CALC: begin
            w_busy = 1'b1;
            if (r_cnt == '0) begin
               w_state_nxt = FIX;
            end
         end
         FIX: begin
            w_busy      = 1'b1;
            w_state_nxt = DONE;
         end
         DONE: begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Operand capture on accept, one step per CALC cycle, sign fix-up into results in FIX
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_rem         <= '0;
         r_quo         <= '0;
         r_dvs         <= '0;
         r_cnt         <= '0;
         r_sign_q      <= 1'b0;
         r_sign_r      <= 1'b0;
         r_divz        <= 1'b0;
         r_quotient    <= '0;
         r_remainder   <= '0;
         r_div_by_zero <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_rem    <= '0;
                  r_quo    <= w_abs_a;
                  r_dvs    <= w_abs_b;
                  r_cnt    <= CNT_W'(WIDTH - 1);
                  r_sign_q <= i_signed_op & (i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1]);
                  r_sign_r <= i_signed_op & i_dividend[WIDTH-1];
                  r_divz   <= (i_divisor == '0);
               end
            end
            CALC: begin
               r_rem <= w_rem_nxt;
               r_quo <= w_quo_nxt;
               r_cnt <= r_cnt - CNT_W'(1);
            end
            FIX: begin
               // With a zero divisor every trial fits, so rem ends as |dividend|;
               // re-applying the dividend sign returns the dividend unchanged.
               r_quotient    <= r_divz ? '0 : (r_sign_q ? -r_quo : r_quo);
               r_remainder   <= r_sign_r ? -r_rem : r_rem;
               r_div_by_zero <= r_divz;
            end
            default: ;
         endcase
      end
   end

   assign o_busy        = w_busy;
   assign o_done        = w_done;
   assign o_quotient    = r_quotient;
   assign o_remainder   = r_remainder;
   assign o_div_by_zero = r_div_by_zero;

endmodule
